// File: rtl/regfile_dump_pkg.sv
// Shared types and helpers for the register-file dump reader.
package regfile_dump_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    HDR,
    B0,
    B1,
    B2,
    B3,
    DONE
  } dump_state_e;

  localparam logic [2:0]  HDR_TAG_DEFAULT = 3'b101;
  localparam int unsigned BYTES_PER_REG   = 4;

  function automatic logic [7:0] hdr_byte(input logic [2:0] tag, input logic [4:0] idx);
    return {tag, idx};
  endfunction

endpackage

// File: rtl/regfile_dump_reader_serializer.sv
// Holds the captured register value and presents its bytes LSB first.
module word_byte_serializer
  import regfile_dump_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [31:0] word,
  input  logic [1:0]  sel,
  input  logic        valid,
  input  logic        ready,
  output logic [7:0]  data,
  output logic        last
);

  logic [31:0] shadow;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow <= '0;
    end else if (load) begin
      shadow <= word;
    end
  end

  always_comb begin
    data = '0;
    case (sel)
      2'd0: data = shadow[7:0];
      2'd1: data = shadow[15:8];
      2'd2: data = shadow[23:16];
      2'd3: data = shadow[31:24];
      default: data = '0;
    endcase
    last = valid && ready && (sel == 2'(BYTES_PER_REG - 1));
  end

endmodule

// File: rtl/regfile_dump_reader.sv
// Walks a register range through one read port and streams each value
// as an optional header byte followed by four data bytes.
module regfile_dump_reader
  import regfile_dump_pkg::*;
#(
  parameter int unsigned FIRST_REG = 0,
  parameter int unsigned LAST_REG  = 31,
  parameter int unsigned HEADER_EN = 1,
  parameter logic [2:0]  HDR_TAG   = HDR_TAG_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  output logic        busy,
  output logic        done,
  output logic [4:0]  rf_addr,
  input  logic [31:0] rf_data,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);

  if (!(FIRST_REG <= LAST_REG && LAST_REG <= 31 && HEADER_EN <= 1)) begin : g_param_check
    $fatal(1, "regfile_dump_reader: illegal FIRST_REG/LAST_REG/HEADER_EN");
  end

  localparam logic [4:0] FIRST_IDX = 5'(FIRST_REG);
  localparam logic [4:0] LAST_IDX  = 5'(LAST_REG);

  dump_state_e state_q, state_d;
  logic [4:0]  idx;
  logic [1:0]  sel;
  logic        byte_phase;
  logic        fire;
  logic [7:0]  ser_data;
  logic        ser_last;

  // idx doubles as the registered read address, so rf_data is settled in LOAD
  assign rf_addr = idx;

  always_comb begin
    sel        = 2'd0;
    byte_phase = 1'b0;
    case (state_q)
      B0: begin sel = 2'd0; byte_phase = 1'b1; end
      B1: begin sel = 2'd1; byte_phase = 1'b1; end
      B2: begin sel = 2'd2; byte_phase = 1'b1; end
      B3: begin sel = 2'd3; byte_phase = 1'b1; end
      default: ;
    endcase
  end

  word_byte_serializer u_ser (
    .clk   (clk),
    .reset (reset),
    .load  (state_q == LOAD),
    .word  (rf_data),
    .sel   (sel),
    .valid (byte_phase),
    .ready (tx_ready),
    .data  (ser_data),
    .last  (ser_last)
  );

  always_comb begin
    tx_valid = byte_phase || (state_q == HDR);
    tx_data  = '0;
    if (state_q == HDR) begin
      tx_data = hdr_byte(HDR_TAG, idx);
    end else if (byte_phase) begin
      tx_data = ser_data;
    end
    busy = tx_valid || (state_q == LOAD);
    done = (state_q == DONE);
    fire = tx_valid && tx_ready;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start) state_d = LOAD;
      LOAD: state_d = (HEADER_EN != 0) ? HDR : B0;
      HDR:  if (fire) state_d = B0;
      B0:   if (fire) state_d = B1;
      B1:   if (fire) state_d = B2;
      B2:   if (fire) state_d = B3;
      B3:   if (ser_last) state_d = (idx == LAST_IDX) ? DONE : LOAD;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // abort wins over start and over a same-cycle handshake
    if (abort) state_d = IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx <= FIRST_IDX;
    end else if (!abort) begin
      if (state_q == IDLE && start) begin
        idx <= FIRST_IDX;
      end else if (ser_last && idx != LAST_IDX) begin
        idx <= idx + 5'd1;
      end
    end
  end

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Self-checking bench: a byte-stream model predicts every transfer, done and busy.
module tb_regfile_dump_reader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, abort, tx_ready;
  logic        busy, done, tx_valid;
  logic [4:0]  rf_addr;
  logic [31:0] rf_data;
  logic [7:0]  tx_data;

  logic        start_b, abort_b, tx_ready_b;
  logic        busy_b, done_b, tx_valid_b;
  logic [4:0]  rf_addr_b;
  logic [31:0] rf_data_b;
  logic [7:0]  tx_data_b;

  logic [31:0] rf [32];
  int          cyc = 0;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] expq [$];
  logic [7:0] log_q [$];
  int         nbytes = 0;
  int         done_pulses = 0;
  bit         done_due = 0;
  bit         idle_now;

  assign rf_data   = rf[rf_addr];
  assign rf_data_b = rf[rf_addr_b];

  regfile_dump_reader dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .abort    (abort),
    .busy     (busy),
    .done     (done),
    .rf_addr  (rf_addr),
    .rf_data  (rf_data),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready)
  );

  regfile_dump_reader #(
    .FIRST_REG (5),
    .LAST_REG  (5),
    .HEADER_EN (0),
    .HDR_TAG   (3'b101)
  ) dut_b (
    .clk      (clk),
    .reset    (reset),
    .start    (start_b),
    .abort    (abort_b),
    .busy     (busy_b),
    .done     (done_b),
    .rf_addr  (rf_addr_b),
    .rf_data  (rf_data_b),
    .tx_data  (tx_data_b),
    .tx_valid (tx_valid_b),
    .tx_ready (tx_ready_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Whole dump of registers 0..31: header {101, r} then the value LSB first.
  function automatic void load_expected();
    logic [31:0] w;
    for (int r = 0; r < 32; r++) begin
      expq.push_back({3'b101, 5'(r)});
      w = rf[r];
      for (int b = 0; b < 4; b++) expq.push_back(w[8*b +: 8]);
    end
  endfunction

  always @(negedge clk) begin
    if (reset) begin
      expq.delete();
      done_due = 0;
    end else begin
      check("done", {31'b0, done}, {31'b0, done_due});
      check("busy", {31'b0, busy}, {31'b0, expq.size() != 0});
      if (expq.size() == 0) check("tx_valid_idle", {31'b0, tx_valid}, 32'd0);
      idle_now = (expq.size() == 0) && !done_due;
      if (done) done_pulses++;
      done_due = 0;
      if (abort) begin
        expq.delete();
      end else begin
        if (tx_valid && tx_ready && expq.size() != 0) begin
          check("tx_byte", {24'b0, tx_data}, {24'b0, expq[0]});
          void'(expq.pop_front());
          log_q.push_back(tx_data);
          nbytes++;
          if (expq.size() == 0) done_due = 1;
        end
        if (start && idle_now) load_expected();
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(output int t);
    start = 1'b1;
    t = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int bound, output int dc);
    bit ok = 0;
    dc = -1;
    for (int i = 0; i < bound; i++) begin
      if (done) begin
        ok = 1;
        dc = cyc;
        break;
      end
      tick();
    end
    check("done_seen", {31'b0, ok}, 32'd1);
  endtask

  task automatic wait_byte(input logic [4:0] a, input logic [7:0] d);
    bit ok = 0;
    for (int i = 0; i < 300; i++) begin
      if (rf_addr == a && tx_valid && tx_data == d) begin
        ok = 1;
        break;
      end
      tick();
    end
    check("byte_seen", {31'b0, ok}, 32'd1);
  endtask

  task automatic new_run();
    nbytes = 0;
    done_pulses = 0;
    log_q.delete();
  endtask

  initial begin
    #300000;
    $display("FAIL timeout: bench did not finish, got running, expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int t, dc;
    logic [7:0] bytes_b [$];

    for (int r = 0; r < 32; r++) rf[r] = 32'h0;
    rf[2] = 32'h7FFF_F000;
    rf[5] = 32'hDEAD_BEEF;
    reset = 1'b1; start = 1'b0; abort = 1'b0; tx_ready = 1'b1;
    start_b = 1'b0; abort_b = 1'b0; tx_ready_b = 1'b1;
    #1;
    check("rst_rf_addr",  {27'b0, rf_addr}, 32'd0);
    check("rst_busy",     {31'b0, busy}, 32'd0);
    check("rst_done",     {31'b0, done}, 32'd0);
    check("rst_tx_valid", {31'b0, tx_valid}, 32'd0);
    check("rst_tx_data",  {24'b0, tx_data}, 32'd0);
    check("rst_b_rf_addr", {27'b0, rf_addr_b}, 32'd5);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    tick();

    // Full dump with stray starts while busy and one in the DONE cycle
    new_run();
    pulse_start(t);
    check("load_busy", {31'b0, busy}, 32'd1);
    tick();
    check("first_byte", {24'b0, tx_data}, 32'hA0);
    repeat (20) tick();
    start = 1'b1; tick(); start = 1'b0;
    repeat (50) tick();
    start = 1'b1; tick(); tick(); start = 1'b0;
    wait_done(400, dc);
    check("done_cycle", dc, t + 193);
    check("busy_at_done", {31'b0, busy}, 32'd0);
    start = 1'b1; tick(); start = 1'b0;
    repeat (10) tick();
    check("byte_count", nbytes, 32'd160);
    check("done_pulses", done_pulses, 32'd1);
    check("idle_after_done_start", {31'b0, busy}, 32'd0);
    check("log_x2_hdr", {24'b0, log_q[10]}, 32'hA2);
    check("log_x2_b0",  {24'b0, log_q[11]}, 32'h00);
    check("log_x2_b1",  {24'b0, log_q[12]}, 32'hF0);
    check("log_x2_b3",  {24'b0, log_q[14]}, 32'h7F);
    check("log_x5_hdr", {24'b0, log_q[25]}, 32'hA5);
    check("log_x5_b0",  {24'b0, log_q[26]}, 32'hEF);
    check("log_x5_b1",  {24'b0, log_q[27]}, 32'hBE);
    check("log_x5_b2",  {24'b0, log_q[28]}, 32'hAD);
    check("log_x5_b3",  {24'b0, log_q[29]}, 32'hDE);
    check("log_x31_hdr", {24'b0, log_q[155]}, 32'hBF);

    // Backpressure on register 5 byte 1
    new_run();
    pulse_start(t);
    wait_byte(5'd5, 8'hBE);
    tx_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("stall_valid", {31'b0, tx_valid}, 32'd1);
      check("stall_data", {24'b0, tx_data}, 32'hBE);
      tick();
    end
    tx_ready = 1'b1;
    tick();
    check("after_stall", {24'b0, tx_data}, 32'hAD);
    wait_done(400, dc);
    check("stall_done_cycle", dc, t + 196);
    tick();
    check("stall_byte_count", nbytes, 32'd160);

    // Single register, no header
    start_b = 1'b1;
    t = cyc;
    tick();
    start_b = 1'b0;
    dc = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (tx_valid_b && tx_ready_b) bytes_b.push_back(tx_data_b);
      if (done_b) begin
        dc = cyc;
        break;
      end
    end
    tick();
    check("b_count", bytes_b.size(), 32'd4);
    if (bytes_b.size() == 4) begin
      check("b_byte0", {24'b0, bytes_b[0]}, 32'hEF);
      check("b_byte1", {24'b0, bytes_b[1]}, 32'hBE);
      check("b_byte2", {24'b0, bytes_b[2]}, 32'hAD);
      check("b_byte3", {24'b0, bytes_b[3]}, 32'hDE);
    end
    check("b_done_cycle", dc, t + 6);
    check("b_idle_busy", {31'b0, busy_b}, 32'd0);

    // Abort during register 3 byte 2
    new_run();
    pulse_start(t);
    wait_byte(5'd3, 8'hA3);
    repeat (3) tick();
    check("abort_pre_valid", {31'b0, tx_valid}, 32'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_valid", {31'b0, tx_valid}, 32'd0);
    check("abort_busy", {31'b0, busy}, 32'd0);
    check("abort_done", {31'b0, done}, 32'd0);
    repeat (5) tick();
    check("abort_no_done", done_pulses, 32'd0);
    new_run();
    pulse_start(t);
    check("restart_addr", {27'b0, rf_addr}, 32'd0);
    wait_done(400, dc);
    check("restart_done_cycle", dc, t + 193);
    tick();
    check("restart_count", nbytes, 32'd160);
    check("restart_first", {24'b0, log_q[0]}, 32'hA0);

    // Asynchronous reset in register 5 byte 1
    new_run();
    pulse_start(t);
    wait_byte(5'd5, 8'hBE);
    #2 reset = 1'b1;
    #1;
    check("arst_valid", {31'b0, tx_valid}, 32'd0);
    check("arst_busy", {31'b0, busy}, 32'd0);
    check("arst_done", {31'b0, done}, 32'd0);
    check("arst_addr", {27'b0, rf_addr}, 32'd0);
    tick();
    reset = 1'b0;
    tick();
    new_run();
    pulse_start(t);
    wait_done(400, dc);
    check("post_rst_done_cycle", dc, t + 193);
    tick();
    check("post_rst_count", nbytes, 32'd160);
    check("post_rst_done_pulses", done_pulses, 32'd1);
    if (log_q.size() == 160) check("post_rst_x5_b3", {24'b0, log_q[29]}, 32'hDE);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
